trace_line_checker: RTL

TRACE_LINE_CHECKER -- requirements
Module: trace_line_checker

---
 rtl/trace_pkg.sv | 37 +++
 rtl/trace_char_class.sv | 17 +
 rtl/trace_line_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the trace line checker.
// States, report codes, error bit positions and grammar characters.
package trace_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TIME,
    S_PC,
    S_SEP,
    S_GRF,
    S_ADDR,
    S_ARROW,
    S_DATA_SP,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  localparam int ERR_PC_ALIGN = 0;
  localparam int ERR_PC_RANGE = 1;
  localparam int ERR_A_ALIGN  = 2;
  localparam int ERR_A_RANGE  = 3;

  localparam logic [7:0] C_CARET  = 8'h5e;
  localparam logic [7:0] C_AT     = 8'h40;
  localparam logic [7:0] C_COLON  = 8'h3a;
  localparam logic [7:0] C_DOLLAR = 8'h24;
  localparam logic [7:0] C_STAR   = 8'h2a;
  localparam logic [7:0] C_LT     = 8'h3c;
  localparam logic [7:0] C_EQ     = 8'h3d;
  localparam logic [7:0] C_HASH   = 8'h23;
  localparam logic [7:0] C_SP     = 8'h20;

endpackage

// File: rtl/trace_char_class.sv
// Character classifier: decimal digit, lowercase hex digit, nibble value.
// Purely combinational.
module trace_char_class (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] hex_val
);

  logic is_af;

  assign is_dec  = (char >= 8'h30) && (char <= 8'h39);
  assign is_af   = (char >= 8'h61) && (char <= 8'h66);
  assign is_hex  = is_dec || is_af;
  assign hex_val = is_dec ? char[3:0] : char[3:0] + 4'd9;

endmodule

// File: rtl/trace_line_checker.sv
// Streaming checker for "^T@P: $G|*A <= D#" trace lines.
// Optional address/PC range checks under TRACE_RANGE_CHECK_EN.
module trace_line_checker #(
  parameter int          TIME_DIG_MAX = 4,
  parameter int          HEX_DIG      = 8,
  parameter int          GRF_DIG_MAX  = 4,
  parameter logic [31:0] PC_MIN       = 32'h0000_3000,
  parameter logic [31:0] PC_MAX       = 32'h0000_6ffc,
  parameter logic [31:0] ADDR_MAX     = 32'h0000_2ffc,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  output logic [1:0]       format_type,
  output logic [3:0]       error_code,
  output logic [CNT_W-1:0] line_count
);
  import trace_pkg::*;

  localparam int M1   = (TIME_DIG_MAX > GRF_DIG_MAX) ? TIME_DIG_MAX : GRF_DIG_MAX;
  localparam int CMAX = (M1 > HEX_DIG) ? M1 : HEX_DIG;
  localparam int CW   = $clog2(CMAX + 2);
  localparam logic [CW-1:0] T_LIM = CW'(TIME_DIG_MAX);
  localparam logic [CW-1:0] G_LIM = CW'(GRF_DIG_MAX);
  localparam logic [CW-1:0] H_LIM = CW'(HEX_DIG);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sp, sp_n;
  logic          mem, mem_n;
  logic          clr, viol, pc_sh, ad_sh;
  logic          is_dec, is_hex;
  logic [3:0]    hex_val;
  logic [1:0]    fmt_d;
  logic [3:0]    err_d;

  trace_char_class u_class (
    .char    (char),
    .is_dec  (is_dec),
    .is_hex  (is_hex),
    .hex_val (hex_val)
  );

  // Saturates one past the field limit so an overlong field never wraps
  function automatic logic [CW-1:0] inc(
    input logic [CW-1:0] v,
    input logic [CW-1:0] lim
  );
    return (v > lim) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      sp    <= 1'b0;
      mem   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sp    <= sp_n;
      mem   <= mem_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sp_n    = sp;
    mem_n   = mem;
    clr     = 1'b0;
    viol    = 1'b0;
    pc_sh   = 1'b0;
    ad_sh   = 1'b0;
    if (char == C_CARET) begin
      state_n = S_TIME;
      cnt_n   = '0;
      sp_n    = 1'b0;
      mem_n   = 1'b0;
      clr     = 1'b1;
    end else begin
      unique case (state)
        S_TIME:
          if (is_dec && cnt < T_LIM) cnt_n = inc(cnt, T_LIM);
          else if (char == C_AT && cnt != '0) begin
            state_n = S_PC;
            cnt_n   = '0;
          end else viol = 1'b1;
        S_PC:
          if (is_hex && cnt < H_LIM) begin
            cnt_n = inc(cnt, H_LIM);
            pc_sh = 1'b1;
          end else if (char == C_COLON && cnt == H_LIM) begin
            state_n = S_SEP;
            cnt_n   = '0;
          end else viol = 1'b1;
        S_SEP:
          if (char == C_SP) state_n = S_SEP;
          else if (char == C_DOLLAR) begin
            state_n = S_GRF;
            mem_n   = 1'b0;
          end else if (char == C_STAR) begin
            state_n = S_ADDR;
            mem_n   = 1'b1;
          end else viol = 1'b1;
        // Leading blanks are skipped; a blank after digits closes the field
        S_GRF:
          if (is_dec && !sp && cnt < G_LIM) cnt_n = inc(cnt, G_LIM);
          else if (char == C_SP) sp_n = (cnt != '0);
          else if (char == C_LT && cnt != '0) begin
            state_n = S_ARROW;
            cnt_n   = '0;
            sp_n    = 1'b0;
          end else viol = 1'b1;
        S_ADDR:
          if (is_hex && !sp && cnt < H_LIM) begin
            cnt_n = inc(cnt, H_LIM);
            ad_sh = 1'b1;
          end else if (char == C_SP && (cnt == '0 || cnt == H_LIM))
            sp_n = (cnt == H_LIM);
          else if (char == C_LT && cnt == H_LIM) begin
            state_n = S_ARROW;
            cnt_n   = '0;
            sp_n    = 1'b0;
          end else viol = 1'b1;
        S_ARROW:
          if (char == C_EQ) state_n = S_DATA_SP;
          else viol = 1'b1;
        S_DATA_SP:
          if (char == C_SP) state_n = S_DATA_SP;
          else if (is_hex) begin
            state_n = S_DATA;
            cnt_n   = CW'(1);
          end else viol = 1'b1;
        S_DATA:
          if (is_hex && cnt < H_LIM) cnt_n = inc(cnt, H_LIM);
          else if (char == C_HASH && cnt == H_LIM) begin
            state_n = S_DONE;
            cnt_n   = '0;
          end else viol = 1'b1;
        default: clr = 1'b1;
      endcase
      if (viol || clr) begin
        state_n = S_IDLE;
        cnt_n   = '0;
        sp_n    = 1'b0;
        mem_n   = 1'b0;
        clr     = 1'b1;
      end
    end
  end

`ifdef TRACE_RANGE_CHECK_EN
  localparam int AW = HEX_DIG * 4;
  localparam logic [AW-1:0] P_MIN = AW'(PC_MIN);
  localparam logic [AW-1:0] P_MAX = AW'(PC_MAX);
  localparam logic [AW-1:0] A_MAX = AW'(ADDR_MAX);

  logic [AW-1:0] pc_acc, addr_acc;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pc_acc   <= '0;
      addr_acc <= '0;
    end else begin
      if (pc_sh) pc_acc <= {pc_acc[AW-5:0], hex_val};
      if (ad_sh) addr_acc <= {addr_acc[AW-5:0], hex_val};
    end
  end

  always_comb begin
    err_d = '0;
    if (state_n == S_DONE) begin
      err_d[ERR_PC_ALIGN] = pc_acc[1:0] != 2'b00;
      err_d[ERR_PC_RANGE] = (pc_acc < P_MIN) || (pc_acc > P_MAX);
      err_d[ERR_A_ALIGN]  = mem_n && (addr_acc[1:0] != 2'b00);
      err_d[ERR_A_RANGE]  = mem_n && (addr_acc > A_MAX);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{PC_MIN, PC_MAX, ADDR_MAX, hex_val, pc_sh, ad_sh};
  assign err_d = '0;
`endif

  always_comb begin
    fmt_d = FMT_NONE;
    if (state_n == S_DONE) fmt_d = mem_n ? FMT_MEM : FMT_REG;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      format_type <= FMT_NONE;
      error_code  <= '0;
      line_count  <= '0;
    end else begin
      format_type <= fmt_d;
      error_code  <= err_d;
      if (state_n == S_DONE && line_count != '1)
        line_count <= line_count + CNT_W'(1);
    end
  end

endmodule
